par_r_demux_s2m: RTL and testbench

Read-data return path of the AXI interconnect. It owns the read-channel state (`READSTATE_*`) that the AR multiplexer consumes, and captures the routing context on the slave-side AR handshake. It pulls R beats from the selected slave through a 2-entry skid buffer and delivers them to the originating master, which is decoded from the upper ID bits. It also checks burst length against `RLAST`.

---
 rtl/par_r_demux_s2m_pkg.sv | 24 ++
 rtl/par_r_demux_s2m_if.sv | 50 +++++
 rtl/par_r_demux_s2m_r_skid_buf.sv | 45 ++++
 rtl/par_r_demux_s2m.sv | 149 ++++++++++++++
 tb/tb_par_r_demux_s2m.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/par_r_demux_s2m_pkg.sv
// Shared AXI read-path constants, read-channel state encoding and the R beat
// payload carried through the skid buffer.
package par_r_demux_s2m_pkg;

  localparam int AXI_IDS_BITS  = 8;
  localparam int AXI_ID_BITS   = 4;
  localparam int AXI_LEN_BITS  = 4;
  localparam int AXI_DATA_BITS = 32;
  localparam int MST_BITS      = AXI_IDS_BITS - AXI_ID_BITS;

  typedef enum logic [1:0] {
    READSTATE_IDLE    = 2'd0,
    READSTATE_ARTRANS = 2'd1,
    READSTATE_RTRANS  = 2'd2
  } read_state_e;

  typedef struct packed {
    logic [AXI_IDS_BITS-1:0]  rid;
    logic [AXI_DATA_BITS-1:0] rdata;
    logic [1:0]               rresp;
    logic                     rlast;
  } r_beat_t;

endpackage

// File: rtl/par_r_demux_s2m_if.sv
// Bundle of the slave-side AR handshake, slave R channels and master R channels
// around the read-data return demux.
// Valid/ready: a beat transfers on a rising clock edge where both valid and ready
// are high; a source never makes valid depend on ready.
interface par_r_demux_s2m_if #(
  parameter int MasterCount = 2,
  parameter int SlaveCount  = 3
);
  import par_r_demux_s2m_pkg::*;

  logic                          ARVALID;
  logic                          ARREADY;
  logic [AXI_IDS_BITS-1:0]       ARID;
  logic [AXI_LEN_BITS-1:0]       ARLEN;
  logic [SlaveCount-1:0]         ARsel_Slave;
  read_state_e                   state;

  logic [SlaveCount-1:0][AXI_IDS_BITS-1:0]   RID_S;
  logic [SlaveCount-1:0][AXI_DATA_BITS-1:0]  RDATA_S;
  logic [SlaveCount-1:0][1:0]                RRESP_S;
  logic [SlaveCount-1:0]                     RLAST_S;
  logic [SlaveCount-1:0]                     RVALID_S;
  logic [SlaveCount-1:0]                     RREADY_S;

  logic [MasterCount-1:0][AXI_ID_BITS-1:0]   RID_M;
  logic [MasterCount-1:0][AXI_DATA_BITS-1:0] RDATA_M;
  logic [MasterCount-1:0][1:0]               RRESP_M;
  logic [MasterCount-1:0]                    RLAST_M;
  logic [MasterCount-1:0]                    RVALID_M;
  logic [MasterCount-1:0]                    RREADY_M;

  logic                          rlast_err;
  logic                          id_err;

  // slave: the demux itself; master: the surrounding fabric/bench driving it
  modport slave (
    input  ARVALID, ARREADY, ARID, ARLEN, ARsel_Slave,
    input  RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S, RREADY_M,
    output state, RREADY_S, RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M,
    output rlast_err, id_err
  );

  modport master (
    output ARVALID, ARREADY, ARID, ARLEN, ARsel_Slave,
    output RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S, RREADY_M,
    input  state, RREADY_S, RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M,
    input  rlast_err, id_err
  );

endinterface

// File: rtl/par_r_demux_s2m_r_skid_buf.sv
// Two-entry skid buffer: full throughput with one cycle of downstream stall
// absorbed. Push is ignored when full, pop when empty.
module r_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic [1:0]   count_o
);

  logic [1:0][W-1:0] mem_q;
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        count_q, count_d;
  logic              do_push, do_pop;

  always_comb begin
    do_push = push_i && (count_q != 2'd2);
    do_pop  = pop_i && (count_q != 2'd0);
    count_d = count_q + 2'(do_push) - 2'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/par_r_demux_s2m.sv
// Read-data return path: tracks the read-channel state, pulls R beats from the
// captured slave through a skid buffer and returns them to the originating master.
module par_r_demux_s2m
  import par_r_demux_s2m_pkg::*;
#(
  parameter int MasterCount = 2,
  parameter int SlaveCount  = 3
) (
  input  logic              ACLK,
  input  logic              ARESET,
  par_r_demux_s2m_if.slave  bus
);

  read_state_e              state_q, state_d;
  logic [SlaveCount-1:0]    sel_s_q, sel_s_d;
  logic [MST_BITS-1:0]      mst_q, mst_d;
  logic [AXI_LEN_BITS-1:0]  len_q, len_d;
  logic [AXI_IDS_BITS-1:0]  id_q, id_d;
  logic [AXI_LEN_BITS-1:0]  pull_cnt_q, pull_cnt_d;
  logic [AXI_LEN_BITS-1:0]  pop_cnt_q, pop_cnt_d;
  logic                     push_done_q, push_done_d;
  logic                     rlast_err_q, rlast_err_d;
  logic                     id_err_q, id_err_d;

  r_beat_t    sel_beat, head;
  logic       sel_rvalid, mst_rready, bad_idx;
  logic       rready_en, push, pop, last_pop, ar_hs;
  logic [1:0] count;

  r_skid_buf #(.W($bits(r_beat_t))) u_skid (
    .clk_i   (ACLK),
    .rst_i   (ARESET),
    .push_i  (push),
    .din_i   (sel_beat),
    .pop_i   (pop),
    .dout_o  (head),
    .count_o (count)
  );

  // Slave/master selection and handshake qualifiers
  always_comb begin
    sel_beat   = '0;
    sel_rvalid = 1'b0;
    for (int s = 0; s < SlaveCount; s++) begin
      if (sel_s_q[s]) begin
        sel_beat.rid   = bus.RID_S[s];
        sel_beat.rdata = bus.RDATA_S[s];
        sel_beat.rresp = bus.RRESP_S[s];
        sel_beat.rlast = bus.RLAST_S[s];
        sel_rvalid     = bus.RVALID_S[s];
      end
    end
    mst_rready = 1'b0;
    for (int m = 0; m < MasterCount; m++) begin
      if (mst_q == MST_BITS'(m)) mst_rready = bus.RREADY_M[m];
    end
    bad_idx   = int'(mst_q) >= MasterCount;
    rready_en = (state_q == READSTATE_RTRANS) && (count != 2'd2) && !push_done_q;
    push      = rready_en && sel_rvalid;
    // A bad master index drains the buffer unconditionally so the slave completes
    pop       = (count != 2'd0) && (bad_idx || mst_rready);
    last_pop  = pop && (pop_cnt_q == len_q);
    ar_hs     = ((state_q == READSTATE_IDLE) && bus.ARVALID && bus.ARREADY) ||
                ((state_q == READSTATE_ARTRANS) && bus.ARREADY);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      READSTATE_IDLE:    if (bus.ARVALID) state_d = bus.ARREADY ? READSTATE_RTRANS
                                                                : READSTATE_ARTRANS;
      READSTATE_ARTRANS: if (bus.ARREADY) state_d = READSTATE_RTRANS;
      READSTATE_RTRANS:  if (last_pop)    state_d = READSTATE_IDLE;
      default:           state_d = READSTATE_IDLE;
    endcase
  end

  always_comb begin
    sel_s_d     = sel_s_q;
    mst_d       = mst_q;
    len_d       = len_q;
    id_d        = id_q;
    pull_cnt_d  = pull_cnt_q;
    pop_cnt_d   = pop_cnt_q;
    push_done_d = push_done_q;
    rlast_err_d = rlast_err_q;
    id_err_d    = id_err_q;
    if (ar_hs) begin
      sel_s_d     = bus.ARsel_Slave;
      mst_d       = bus.ARID[AXI_IDS_BITS-1:AXI_ID_BITS];
      len_d       = bus.ARLEN;
      id_d        = bus.ARID;
      pull_cnt_d  = '0;
      pop_cnt_d   = '0;
      push_done_d = 1'b0;
      if (int'(bus.ARID[AXI_IDS_BITS-1:AXI_ID_BITS]) >= MasterCount) id_err_d = 1'b1;
    end
    if (push) begin
      pull_cnt_d = pull_cnt_q + 1'b1;
      if (pull_cnt_q == len_q) push_done_d = 1'b1;
      if (sel_beat.rlast != (pull_cnt_q == len_q)) rlast_err_d = 1'b1;
      if (sel_beat.rid != id_q) id_err_d = 1'b1;
    end
    if (pop) pop_cnt_d = pop_cnt_q + 1'b1;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= READSTATE_IDLE;
      sel_s_q     <= '0;
      mst_q       <= '0;
      len_q       <= '0;
      id_q        <= '0;
      pull_cnt_q  <= '0;
      pop_cnt_q   <= '0;
      push_done_q <= 1'b0;
      rlast_err_q <= 1'b0;
      id_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_s_q     <= sel_s_d;
      mst_q       <= mst_d;
      len_q       <= len_d;
      id_q        <= id_d;
      pull_cnt_q  <= pull_cnt_d;
      pop_cnt_q   <= pop_cnt_d;
      push_done_q <= push_done_d;
      rlast_err_q <= rlast_err_d;
      id_err_q    <= id_err_d;
    end
  end

  // RLAST_M follows our own beat count, not the slave's RLAST
  always_comb begin
    for (int m = 0; m < MasterCount; m++) begin
      bus.RID_M[m]    = head.rid[AXI_ID_BITS-1:0];
      bus.RDATA_M[m]  = head.rdata;
      bus.RRESP_M[m]  = head.rresp;
      bus.RLAST_M[m]  = (count != 2'd0) && (pop_cnt_q == len_q);
      bus.RVALID_M[m] = (count != 2'd0) && !bad_idx && (mst_q == MST_BITS'(m));
    end
  end

  assign bus.state     = state_q;
  assign bus.RREADY_S  = sel_s_q & {SlaveCount{rready_en}};
  assign bus.rlast_err = rlast_err_q;
  assign bus.id_err    = id_err_q;

endmodule

// File: tb/tb_par_r_demux_s2m.sv
// Directed bench for the read-data return demux: single beat, AR wait states,
// stalled burst, RLAST mismatch, bad master index and mid-burst reset.
module tb_par_r_demux_s2m;
  import par_r_demux_s2m_pkg::*;

  logic ACLK = 1'b0;
  logic ARESET;
  int   checks = 0;
  int   passes = 0;

  par_r_demux_s2m_if bus ();

  par_r_demux_s2m dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .bus    (bus)
  );

  always #5 ACLK = ~ACLK;

  task automatic cycle();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_ar(input logic [7:0] id, input logic [3:0] len,
                       input logic [2:0] sel, input int waits);
    for (int k = 0; k <= waits; k++) begin
      bus.ARVALID     = 1'b1;
      bus.ARID        = id;
      bus.ARLEN       = len;
      bus.ARsel_Slave = sel;
      bus.ARREADY     = (k == waits);
      if (k > 0) chk("ar_wait_state", 64'(bus.state), 64'(READSTATE_ARTRANS));
      cycle();
    end
    bus.ARVALID = 1'b0;
    bus.ARREADY = 1'b0;
    chk("ar_done_state", 64'(bus.state), 64'(READSTATE_RTRANS));
  endtask

  // Plays slave s (one beat per handshake, data = base + beat) and master m
  // (ready from rdy_pat) until the FSM leaves RTRANS; records per-cycle traces.
  task automatic run_r(input string tag, input int s, input int m, input logic [7:0] id,
                       input int len, input int rlast_at, input logic [31:0] base,
                       input logic [7:0] rdy_pat, output int nw, output int npush,
                       output int npop, output logic [15:0] rrs_tr, output logic [15:0] rv_tr);
    logic [3:0] lid;
    lid    = id[3:0];
    nw     = 0;
    npush  = 0;
    npop   = 0;
    rrs_tr = '0;
    rv_tr  = '0;
    while (bus.state == READSTATE_RTRANS && nw < 40) begin
      bus.RVALID_S = '0;
      if (npush <= len) begin
        bus.RVALID_S[s] = 1'b1;
        bus.RID_S[s]    = id;
        bus.RDATA_S[s]  = base + 32'(npush);
        bus.RRESP_S[s]  = 2'b00;
        bus.RLAST_S[s]  = (npush == rlast_at);
      end
      bus.RREADY_M = '0;
      if (m < 2) bus.RREADY_M[m] = rdy_pat[nw % 8];
      #1;
      rrs_tr[nw] = bus.RREADY_S[s];
      rv_tr[nw]  = |bus.RVALID_M;
      if (bus.RREADY_S[s] && bus.RVALID_S[s]) npush++;
      if (m < 2 && bus.RVALID_M[m] && bus.RREADY_M[m]) begin
        chk({tag, "_rdata"}, 64'(bus.RDATA_M[m]), 64'(base + 32'(npop)));
        chk({tag, "_rid"},   64'(bus.RID_M[m]),   64'(lid));
        chk({tag, "_rlast"}, 64'(bus.RLAST_M[m]), 64'(npop == len));
        npop++;
      end
      nw++;
      cycle();
    end
    bus.RVALID_S = '0;
    bus.RREADY_M = '0;
    chk({tag, "_timeout"}, 64'(nw < 40), 64'(1));
    chk({tag, "_idle"}, 64'(bus.state), 64'(READSTATE_IDLE));
  endtask

  initial begin
    int nw, npush, npop;
    logic [15:0] rrs_tr, rv_tr;

    bus.ARVALID = 1'b0;  bus.ARREADY = 1'b0;  bus.ARID = '0;
    bus.ARLEN = '0;      bus.ARsel_Slave = '0;
    bus.RID_S = '0;      bus.RDATA_S = '0;    bus.RRESP_S = '0;
    bus.RLAST_S = '0;    bus.RVALID_S = '0;   bus.RREADY_M = '0;
    ARESET = 1'b1;
    cycle();
    cycle();
    ARESET = 1'b0;
    chk("rst_state",     64'(bus.state),     64'(READSTATE_IDLE));
    chk("rst_rvalid_m",  64'(bus.RVALID_M),  64'(0));
    chk("rst_rready_s",  64'(bus.RREADY_S),  64'(0));
    chk("rst_rdata_m",   64'(bus.RDATA_M),   64'(0));
    chk("rst_errs",      64'({bus.rlast_err, bus.id_err}), 64'(0));

    // Single beat: ARID 12 -> master 1, slave 1, DEADBEEF
    do_ar(8'h12, 4'd0, 3'b010, 0);
    run_r("single", 1, 1, 8'h12, 0, 0, 32'hDEADBEEF, 8'hFF, nw, npush, npop, rrs_tr, rv_tr);
    chk("single_nw",    64'(nw),     64'(2));
    chk("single_pops",  64'(npop),   64'(1));
    chk("single_rrs",   64'(rrs_tr), 64'(16'h0001));
    chk("single_rv",    64'(rv_tr),  64'(16'h0002));

    // Three AR wait cycles: IDLE then ARTRANS x3, then RTRANS
    do_ar(8'h0A, 4'd0, 3'b001, 3);
    run_r("delayed", 0, 0, 8'h0A, 0, 0, 32'h0000_00A5, 8'hFF, nw, npush, npop, rrs_tr, rv_tr);
    chk("delayed_pops", 64'(npop), 64'(1));

    // 4-beat burst, slave 2 -> master 1, master ready 1,0,0,1,1,1 from first valid
    do_ar(8'h13, 4'd3, 3'b100, 0);
    run_r("burst", 2, 1, 8'h13, 3, 3, 32'h1111_0000, 8'b1111_0011, nw, npush, npop, rrs_tr, rv_tr);
    chk("burst_nw",     64'(nw),     64'(7));
    chk("burst_pushes", 64'(npush),  64'(4));
    chk("burst_pops",   64'(npop),   64'(4));
    chk("burst_rrs",    64'(rrs_tr), 64'(16'h0027));
    chk("burst_rv",     64'(rv_tr),  64'(16'h007E));
    chk("burst_errs",   64'({bus.rlast_err, bus.id_err}), 64'(0));

    // Slave raises RLAST on beat 2 of 4
    do_ar(8'h01, 4'd3, 3'b001, 0);
    run_r("early_last", 0, 0, 8'h01, 3, 1, 32'h2222_0000, 8'hFF, nw, npush, npop, rrs_tr, rv_tr);
    chk("early_last_pops", 64'(npop),          64'(4));
    chk("early_last_rrs",  64'(rrs_tr),        64'(16'h000F));
    chk("early_last_rlerr", 64'(bus.rlast_err), 64'(1));
    chk("early_last_iderr", 64'(bus.id_err),    64'(0));

    // Master index 5 does not exist: slave drains, no master sees valid
    do_ar(8'h53, 4'd3, 3'b010, 0);
    run_r("bad_idx", 1, 5, 8'h53, 3, 3, 32'h3333_0000, 8'hFF, nw, npush, npop, rrs_tr, rv_tr);
    chk("bad_idx_nw",     64'(nw),         64'(5));
    chk("bad_idx_drain",  64'(npush),      64'(4));
    chk("bad_idx_rv",     64'(rv_tr),      64'(0));
    chk("bad_idx_iderr",  64'(bus.id_err), 64'(1));

    // Reset asserted while beat 2 of 4 is offered
    do_ar(8'h14, 4'd3, 3'b010, 0);
    bus.RVALID_S[1] = 1'b1; bus.RID_S[1] = 8'h14; bus.RDATA_S[1] = 32'h1000;
    bus.RLAST_S[1] = 1'b0;  bus.RREADY_M = 2'b10;
    cycle();
    bus.RDATA_S[1] = 32'h1001;
    ARESET = 1'b1;
    #1;
    chk("pre_rst_rvalid", 64'(bus.RVALID_M), 64'(2'b10));
    cycle();
    ARESET = 1'b0;
    bus.RVALID_S = '0;
    bus.RREADY_M = '0;
    chk("mid_rst_state",    64'(bus.state),     64'(READSTATE_IDLE));
    chk("mid_rst_rvalid_m", 64'(bus.RVALID_M),  64'(0));
    chk("mid_rst_rready_s", 64'(bus.RREADY_S),  64'(0));
    chk("mid_rst_rlast_err", 64'(bus.rlast_err), 64'(0));
    chk("mid_rst_id_err",   64'(bus.id_err),    64'(0));

    // Recovery after reset
    do_ar(8'h12, 4'd0, 3'b010, 0);
    run_r("post_rst", 1, 1, 8'h12, 0, 0, 32'hCAFE_F00D, 8'hFF, nw, npush, npop, rrs_tr, rv_tr);
    chk("post_rst_pops", 64'(npop), 64'(1));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
